rgmii_rx_packer: RTL and testbench
==================================

// Module: rgmii_rx_packer
// PURPOSE
// Parametrised RGMII receive framer in the RXC domain: takes the registered DDR capture pair of {RX_CTL,RXD},
// decodes in-band link status, strips preamble/SFD, and assembles bytes into BYTES-wide words.
// Word stream carries SOF/EOF/byte-enables, a frame length and error codes.
// Supports 1000 (byte per RXC) and 10/100 (nibble per RXC) modes; no backpressure (line-rate sink).
// PARAMETERS
// BYTES    4     output word width in bytes (1, 2, 4 or 8)
// MIN_LEN  64    shortest legal frame in bytes after SFD; shorter sets runt flag
// MAX_LEN  1522  longest legal frame; bytes beyond are dropped, oversize flag set
// INBAND   1     1: speed from in-band status; 0: speed from SPEED_CFG
// PORTS
// RXC        in   1          receive clock, sole clock
// RST_N      in   1          asynchronous active-low reset
// DDR_R      in   5          {RX_CTL,RXD} sampled on RXC rising edge
// DDR_F      in   5          {RX_CTL,RXD} sampled on RXC falling edge, same cycle
// SPEED_CFG  in   2          forced speed when INBAND=0 (2'b10 = 1000, else nibble mode)
// DATA_OUT   out  8*BYTES    packed data, byte 0 = first received byte in bits [7:0]
// BE         out  BYTES      byte enables, contiguous from bit 0
// VALID      out  1          one-cycle word strobe
// SOF        out  1          first word of frame, qualified by VALID
// EOF        out  1          last word of frame, qualified by VALID
// ERR_CODE   out  4          on EOF beat: [0] RX_ER seen, [1] runt, [2] oversize, [3] odd nibble count
// FRAME_LEN  out  16         on EOF beat: bytes after SFD, saturating at 16'hFFFF
// LINK_UP    out  1          in-band link status
// DUPLEX     out  1          in-band duplex, 1 = full
// SPEED      out  2          in-band speed code (00=10, 01=100, 10=1000)
// BEHAVIOUR
// Reset: every output 0, FSM in WAIT_IDLE, word buffer and counters cleared.
// DV = DDR_R[4]; ER = DDR_R[4]^DDR_F[4].
// Status: when DV=0 and ER=0, register LINK_UP=RXD[0], SPEED=RXD[2:1], DUPLEX=RXD[3] from DDR_R; otherwise hold.
// Mode (byte vs nibble) is latched at DV rising edge; speed change mid-frame has no effect until next frame.
// Byte mode: byte = {DDR_F[3:0],DDR_R[3:0]} each cycle. Nibble mode: nibble = DDR_R[3:0], low nibble first.
// FSM:
//  WAIT_IDLE: entered after reset; go IDLE when DV=0, so a frame in progress at reset release is ignored.
//  IDLE: DV=1 -> PREAMBLE.
//  PREAMBLE: byte mode: byte 8'hD5 -> DATA. Nibble mode: nibble 4'hD following 4'h5 -> DATA, nibble phase resets.
//    Any count of 0x5 accepted. DV=0 in PREAMBLE -> IDLE, no output.
//  DATA: bytes enter word buffer at lane = count mod BYTES; count increments per byte.
//    Byte MAX_LEN+1 and later discarded (state DROP), oversize flag set.
//  DROP: as DATA but no bytes stored; DV=0 ends frame.
//  DV=0 in DATA/DROP -> emit EOF beat, -> IDLE.
// Holdback: a full word is held until the first byte of the next word arrives, then emitted VALID=1, EOF=0.
// On DV fall the held or partial word is emitted with EOF=1, BE = lanes filled, FRAME_LEN, ERR_CODE.
// Latency: EOF beat VALID exactly one RXC after the first cycle with DV=0.
// SOF=1 on the first emitted word only. A frame with zero bytes after SFD emits a single beat:
//   SOF=EOF=1, BE=0, FRAME_LEN=0, ERR_CODE[1]=1.
// ER=1 on any DATA/DROP cycle sets ERR_CODE[0]. Nibble mode ending with an unpaired nibble sets ERR_CODE[3];
//   the partial byte is discarded.
// Runt: count < MIN_LEN at EOF. Error flags are sticky per frame and cleared at the next SFD.
// Back-to-back frames: DV low one cycle then high is legal; the EOF beat and the new frame's preamble overlap without loss.
// TESTING
// 1000, BYTES=4, preamble 7x55 + D5, 64 bytes 0x00..0x3F -> 16 beats, first SOF DATA_OUT=32'h03020100,
//   last EOF BE=4'hF, LEN=64, ERR=0.
// 100 mode, BYTES=4, 65-byte frame -> 17 beats, last BE=4'h1, LEN=65; each data byte consumes 2 RXC.
// 1000 mode, ER pulse on byte 10 of 100-byte frame -> EOF ERR_CODE=4'b0001, LEN=100; 40-byte frame -> ERR_CODE=4'b0010.
// MAX_LEN=1522, 1600-byte frame -> 381 beats, last EOF BE=4'h3, LEN=1600, ERR_CODE[2]=1.
// Nibble mode, DV drops after odd nibble -> ERR_CODE[3]=1, partial byte absent.
//   DV high during RST_N release -> no output until DV low then high.
// Idle DDR_R=5'h0D, DDR_F=5'h0D -> LINK_UP=1, SPEED=2'b10, DUPLEX=1; no VALID.

Source files
------------

// File: rtl/rgmii_rx_packer_if.sv
// Bus between the RGMII receive framer and the logic around it.
//   ddr_r / ddr_f  : {RX_CTL,RXD} captured on the rising / falling RXC edge
//   speed_cfg      : forced speed used when in-band status is disabled
//   data_out, be, valid, sof, eof, err_code, frame_len : packed word stream
//   link_up, duplex, speed : decoded in-band link status
// slave is the framer side, master is the side that drives the pins and sinks words.
interface rgmii_rx_packer_if #(
    parameter int unsigned BYTES = 4
);
    logic [4:0]         ddr_r;
    logic [4:0]         ddr_f;
    logic [1:0]         speed_cfg;
    logic [8*BYTES-1:0] data_out;
    logic [BYTES-1:0]   be;
    logic               valid;
    logic               sof;
    logic               eof;
    logic [3:0]         err_code;
    logic [15:0]        frame_len;
    logic               link_up;
    logic               duplex;
    logic [1:0]         speed;

    modport slave (
        input  ddr_r, ddr_f, speed_cfg,
        output data_out, be, valid, sof, eof, err_code, frame_len, link_up, duplex, speed
    );

    modport master (
        output ddr_r, ddr_f, speed_cfg,
        input  data_out, be, valid, sof, eof, err_code, frame_len, link_up, duplex, speed
    );
endinterface

// File: rtl/rgmii_rx_packer.sv
// RGMII receive framer in the RXC domain: decodes in-band link status, strips
// preamble/SFD and packs received bytes into BYTES-wide words with SOF/EOF,
// byte enables, frame length and error code on the closing beat.
// Ports:
//   i_rxc   : receive clock, sole clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : slave side of rgmii_rx_packer_if (DDR capture pair in, word stream
//             and link status out; all outputs registered)
module rgmii_rx_packer #(
    parameter int unsigned BYTES   = 4,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    parameter bit          INBAND  = 1'b1
) (
    input  logic             i_rxc,
    input  logic             i_rst_n,
    rgmii_rx_packer_if.slave io_bus
);
    localparam int unsigned DW = 8 * BYTES;
    localparam int unsigned LW = $clog2(BYTES + 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_word;
    logic [LW-1:0] r_nlane;
    logic [15:0]   r_cnt;
    logic          r_first;
    logic          r_er;
    logic          r_oversize;
    logic          r_nib_mode;
    logic          r_nib_hi;
    logic [3:0]    r_nib_lo;
    logic          r_last5;

    logic [DW-1:0]    r_data;
    logic [BYTES-1:0] r_be;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;
    logic [3:0]       r_err;
    logic [15:0]      r_len;
    logic             r_link;
    logic             r_duplex;
    logic [1:0]       r_speed;

    logic       w_dv;
    logic       w_er;
    logic [3:0] w_nib;
    logic [7:0] w_ddr_byte;
    logic [7:0] w_byte;
    logic       w_byte_rdy;
    logic       w_sfd;
    logic [1:0] w_speed_sel;

    assign w_dv        = io_bus.ddr_r[4];
    assign w_er        = io_bus.ddr_r[4] ^ io_bus.ddr_f[4];
    assign w_nib       = io_bus.ddr_r[3:0];
    assign w_ddr_byte  = {io_bus.ddr_f[3:0], io_bus.ddr_r[3:0]};
    assign w_speed_sel = INBAND ? r_speed : io_bus.speed_cfg;
    // In nibble mode a byte completes on the high-nibble cycle, low nibble held from the previous one.
    assign w_byte_rdy  = r_nib_mode ? r_nib_hi : 1'b1;
    assign w_byte      = r_nib_mode ? {w_nib, r_nib_lo} : w_ddr_byte;
    assign w_sfd       = r_nib_mode ? ((w_nib == 4'hD) && r_last5) : (w_ddr_byte == 8'hD5);

    // Byte enables for the number of lanes currently filled.
    function automatic logic [BYTES-1:0] f_be(input logic [LW-1:0] n);
        logic [BYTES-1:0] be;
        be = '0;
        for (int i = 0; i < BYTES; i++) begin
            be[i] = (LW'(i) < n);
        end
        return be;
    endfunction

    // Framer state machine, word packer and status decode.
    always_ff @(posedge i_rxc or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_WAIT_IDLE;
            r_word     <= '0;
            r_nlane    <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_er       <= 1'b0;
            r_oversize <= 1'b0;
            r_nib_mode <= 1'b0;
            r_nib_hi   <= 1'b0;
            r_nib_lo   <= '0;
            r_last5    <= 1'b0;
            r_data     <= '0;
            r_be       <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_err      <= '0;
            r_len      <= '0;
            r_link     <= 1'b0;
            r_duplex   <= 1'b0;
            r_speed    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;

            // In-band status is only meaningful in normal inter-frame idle.
            if (!w_dv && !w_er) begin
                r_link   <= io_bus.ddr_r[0];
                r_speed  <= io_bus.ddr_r[2:1];
                r_duplex <= io_bus.ddr_r[3];
            end

            case (r_state)
                S_WAIT_IDLE: begin
                    if (!w_dv) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    // IDLE is only held while DV is low, so DV high here is the rising edge.
                    if (w_dv) begin
                        r_state    <= S_PREAMBLE;
                        r_nib_mode <= (w_speed_sel != 2'b10);
                        r_last5    <= (w_nib == 4'h5);
                    end
                end
                S_PREAMBLE: begin
                    if (!w_dv) begin
                        r_state <= S_IDLE;
                    end else if (w_sfd) begin
                        r_state    <= S_DATA;
                        r_word     <= '0;
                        r_nlane    <= '0;
                        r_cnt      <= '0;
                        r_first    <= 1'b1;
                        r_er       <= 1'b0;
                        r_oversize <= 1'b0;
                        r_nib_hi   <= 1'b0;
                    end else begin
                        r_last5 <= (w_nib == 4'h5);
                    end
                end
                S_DATA, S_DROP: begin
                    if (!w_dv) begin
                        // Closing beat: held or partial word plus frame summary.
                        r_state <= S_IDLE;
                        r_valid <= 1'b1;
                        r_sof   <= r_first;
                        r_eof   <= 1'b1;
                        r_data  <= r_word;
                        r_be    <= f_be(r_nlane);
                        r_len   <= r_cnt;
                        r_err   <= {r_nib_mode & r_nib_hi, r_oversize,
                                    (32'(r_cnt) < MIN_LEN), r_er | w_er};
                    end else begin
                        if (w_er) r_er <= 1'b1;
                        if (r_nib_mode) begin
                            r_nib_hi <= ~r_nib_hi;
                            if (!r_nib_hi) r_nib_lo <= w_nib;
                        end
                        if (w_byte_rdy) begin
                            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                            if (r_state == S_DATA) begin
                                if (32'(r_cnt) < MAX_LEN) begin
                                    if (r_nlane == LW'(BYTES)) begin
                                        // Full word is released only once the next word has a byte.
                                        r_valid <= 1'b1;
                                        r_sof   <= r_first;
                                        r_data  <= r_word;
                                        r_be    <= '1;
                                        r_first <= 1'b0;
                                        r_word  <= DW'(w_byte);
                                        r_nlane <= LW'(1);
                                    end else begin
                                        for (int i = 0; i < BYTES; i++) begin
                                            if (LW'(i) == r_nlane) r_word[8*i +: 8] <= w_byte;
                                        end
                                        r_nlane <= r_nlane + LW'(1);
                                    end
                                end else begin
                                    r_state    <= S_DROP;
                                    r_oversize <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

    assign io_bus.data_out  = r_data;
    assign io_bus.be        = r_be;
    assign io_bus.valid     = r_valid;
    assign io_bus.sof       = r_sof;
    assign io_bus.eof       = r_eof;
    assign io_bus.err_code  = r_err;
    assign io_bus.frame_len = r_len;
    assign io_bus.link_up   = r_link;
    assign io_bus.duplex    = r_duplex;
    assign io_bus.speed     = r_speed;
endmodule

// File: tb/tb_rgmii_rx_packer.sv
// Directed + randomized bench for rgmii_rx_packer (BYTES=4, MIN_LEN=64, MAX_LEN=1522).
module tb_rgmii_rx_packer;
    localparam int unsigned BYTES   = 4;
    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 1522;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rgmii_rx_packer_if #(.BYTES(BYTES)) bus ();

    rgmii_rx_packer #(
        .BYTES  (BYTES),
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .INBAND (1'b1)
    ) dut (
        .i_rxc  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    logic [7:0]  frame_q[$];
    logic [63:0] exp_q[$];
    int          exp_eof_q[$];
    logic [63:0] obs_q[$];
    int          obs_cyc_q[$];
    logic [3:0]  cur_st = 4'hD;

    // Beat image: {len, err, sof, eof, be, data}; data masked by be, len/err only on eof.
    function automatic logic [63:0] pack_beat(input logic [31:0] d, input logic [3:0] be,
                                              input logic sof, input logic eof,
                                              input logic [3:0] err, input logic [15:0] len);
        logic [31:0] m;
        m = '0;
        for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = d[8*l +: 8];
        return {6'd0, eof ? len : 16'd0, eof ? err : 4'd0, sof, eof, be, m};
    endfunction

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            obs_q.push_back(pack_beat(bus.data_out, bus.be, bus.sof, bus.eof,
                                      bus.err_code, bus.frame_len));
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] f);
        @(posedge clk);
        #1;
        bus.ddr_r = r;
        bus.ddr_f = f;
    endtask

    task automatic idle(input int n);
        repeat (n) drive({1'b0, cur_st}, {1'b0, cur_st});
    endtask

    // Expected beats from the frame contents: words of 4, stored bytes capped at MAX_LEN.
    task automatic build_expected(input bit er, input bit odd);
        int n, stored, nb, lanes;
        logic [31:0] d;
        logic [3:0]  be;
        logic [15:0] len;
        n      = frame_q.size();
        stored = (n < int'(MAX_LEN)) ? n : int'(MAX_LEN);
        nb     = (stored == 0) ? 1 : (stored + 3) / 4;
        len    = (n > 65535) ? 16'hFFFF : 16'(n);
        for (int w = 0; w < nb; w++) begin
            lanes = stored - 4 * w;
            if (lanes > 4) lanes = 4;
            d = '0;
            for (int l = 0; l < lanes; l++) d[8*l +: 8] = frame_q[4*w + l];
            be = 4'((1 << lanes) - 1);
            exp_q.push_back(pack_beat(d, be, w == 0, w == nb - 1,
                                      {odd, n > int'(MAX_LEN), n < int'(MIN_LEN), er}, len));
        end
    endtask

    // Preamble, SFD, frame_q data, then one idle cycle (first DV-low cycle).
    task automatic send_frame(input bit nib, input int er_idx, input bit odd);
        logic [7:0] b;
        logic       e;
        repeat (nib ? 15 : 7) drive(5'h15, 5'h15);
        if (nib) drive(5'h1D, 5'h1D);
        else     drive(5'h15, 5'h1D);
        for (int i = 0; i < frame_q.size(); i++) begin
            b = frame_q[i];
            e = (i == er_idx);
            if (nib) begin
                drive({1'b1, b[3:0]}, {~e, b[3:0]});
                drive({1'b1, b[7:4]}, {1'b1, b[7:4]});
            end else begin
                drive({1'b1, b[3:0]}, {~e, b[7:4]});
            end
        end
        if (nib && odd) drive(5'h1A, 5'h1A);
        idle(1);
        exp_eof_q.push_back(cyc + 1);
        build_expected(er_idx >= 0 && er_idx < frame_q.size(), nib && odd);
        frame_q.delete();
    endtask

    task automatic fill_random(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_frames(input string tag);
        int k;
        chk({tag, " beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), obs_q[i], exp_q[i]);
        k = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i][36]) begin
                if (k < exp_eof_q.size())
                    chk($sformatf("%s eof latency%0d", tag, k), 64'(obs_cyc_q[i]), 64'(exp_eof_q[k]));
                k++;
            end
        end
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_eof_q.delete();
    endtask

    initial begin
        int n, er;
        logic [63:0] first;
        bus.ddr_r     = '0;
        bus.ddr_f     = '0;
        bus.speed_cfg = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset outputs", 64'({bus.data_out, bus.be, bus.valid, bus.sof, bus.eof, bus.err_code,
                                  bus.frame_len, bus.link_up, bus.duplex, bus.speed}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle status decode, 1000 mode
        cur_st = 4'hD;
        idle(4);
        @(negedge clk);
        chk("status 1000", 64'({bus.link_up, bus.duplex, bus.speed}), 64'(4'b1110));
        chk("idle no valid", 64'(obs_q.size()), 64'd0);

        // 64-byte incrementing frame
        for (int i = 0; i < 64; i++) frame_q.push_back(8'(i));
        send_frame(1'b0, -1, 1'b0);
        idle(4);
        first = (obs_q.size() > 0) ? obs_q[0] : '1;
        chk("first word", 64'({first[37], first[31:0]}), 64'({1'b1, 32'h03020100}));
        check_frames("inc64");

        // ER on byte 10 of 100, runt 40, oversize 1600
        fill_random(100); send_frame(1'b0, 10, 1'b0); idle(3); check_frames("er100");
        fill_random(40);  send_frame(1'b0, -1, 1'b0); idle(3); check_frames("runt40");
        fill_random(1600); send_frame(1'b0, -1, 1'b0); idle(3); check_frames("over1600");

        // Randomized byte-mode frames, including empty ones
        for (int t = 0; t < 6; t++) begin
            n  = (t == 0) ? 0 : $urandom_range(1, 140);
            er = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            fill_random(n);
            send_frame(1'b0, er, 1'b0);
            idle(3);
            check_frames($sformatf("rand1000_%0d", t));
        end

        // Back-to-back: one DV-low cycle between frames
        fill_random(70); send_frame(1'b0, -1, 1'b0);
        fill_random(21); send_frame(1'b0, 5, 1'b0);
        idle(3);
        check_frames("b2b");

        // Nibble mode (100M in-band)
        cur_st = 4'hB;
        idle(3);
        @(negedge clk);
        chk("status 100", 64'({bus.link_up, bus.duplex, bus.speed}), 64'(4'b1101));
        fill_random(65); send_frame(1'b1, -1, 1'b0); idle(3); check_frames("nib65");
        fill_random(30); send_frame(1'b1, -1, 1'b1); idle(3); check_frames("nibodd");
        for (int t = 0; t < 4; t++) begin
            n  = $urandom_range(0, 90);
            er = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            fill_random(n);
            send_frame(1'b1, er, 1'($urandom_range(0, 1)));
            idle(3);
            check_frames($sformatf("randnib_%0d", t));
        end

        // DV high across reset release: that frame must be ignored
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) drive(5'h15, 5'h15);
        rst_n = 1'b1;
        repeat (4) drive(5'h15, 5'h15);
        drive(5'h15, 5'h1D);
        repeat (20) drive(5'h13, 5'h1A);
        cur_st = 4'hD;
        idle(4);
        @(negedge clk);
        chk("no output after reset mid-frame", 64'(obs_q.size()), 64'd0);
        chk("status after reset", 64'({bus.link_up, bus.duplex, bus.speed}), 64'(4'b1110));
        fill_random(80); send_frame(1'b0, -1, 1'b0); idle(3); check_frames("post reset");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
